// File: rtl/risc_spm_pkg.sv
// Package: risc_spm_pkg
// Shared definitions for the RISC-SPM processor. The ALU and the control unit both import this
// package, so opcode values are defined in one place only.
//   - opcode_e       : instruction opcodes, which are also the ALU operation selects
//   - state_e        : control unit state encodings
//   - Sel1* / Sel2*  : Bus_1 / Bus_2 multiplexer select values
//   - get_opcode/get_src/get_dest : instruction field slices
package risc_spm_pkg;

   localparam int unsigned word_size  = 8;
   localparam int unsigned op_size    = 4;
   localparam int unsigned state_size = 4;

   typedef enum logic [3:0] {
      OpNop = 4'h0,
      OpAdd = 4'h1,
      OpSub = 4'h2,
      OpAnd = 4'h3,
      OpNot = 4'h4,
      OpRd  = 4'h5,
      OpWr  = 4'h6,
      OpBr  = 4'h7,
      OpBrz = 4'h8,
      OpEqz = 4'h9,
      OpLdr = 4'hA
   } opcode_e;

   typedef enum logic [3:0] {
      StIdle = 4'd0,
      StFet1 = 4'd1,
      StFet2 = 4'd2,
      StDec  = 4'd3,
      StEx1  = 4'd4,
      StRd1  = 4'd5,
      StRd2  = 4'd6,
      StWr1  = 4'd7,
      StWr2  = 4'd8,
      StBr1  = 4'd9,
      StBr2  = 4'd10,
      StHalt = 4'd11
   } state_e;

   // Bus_1 select: 0..3 pick R0..R3, 4 picks the PC
   localparam logic [2:0] Sel1Pc   = 3'd4;

   // Bus_2 select
   localparam logic [1:0] Sel2Alu  = 2'd0;
   localparam logic [1:0] Sel2Bus1 = 2'd1;
   localparam logic [1:0] Sel2Mem  = 2'd2;

   function automatic logic [3:0] get_opcode(input logic [word_size-1:0] instr);
      return instr[7:4];
   endfunction

   function automatic logic [1:0] get_src(input logic [word_size-1:0] instr);
      return instr[3:2];
   endfunction

   function automatic logic [1:0] get_dest(input logic [word_size-1:0] instr);
      return instr[1:0];
   endfunction

endpackage

// File: rtl/control_unit_risc.sv
// Module: control_unit_risc
// Fetch/decode/execute sequencer for the RISC-SPM datapath. The state is registered. The control
// outputs are decoded combinationally from the state, the IR contents and the Reg_Z flag.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, returns to StIdle
//   instruction  IR contents: opcode [7:4], src [3:2], dest [1:0]
//   zero         registered ALU zero flag (Reg_Z), used only in StDec
//   load_r       one-hot load enable for R0..R3
//   load_pc      PC <= Bus_2
//   inc_pc       PC <= PC + 1
//   sel_bus_1    Bus_1 source: 0..3 = R0..R3, 4 = PC
//   sel_bus_2    Bus_2 source: 0 = ALU, 1 = Bus_1, 2 = memory
//   load_ir      IR <= Bus_2
//   load_add_r   Add_R <= Bus_2
//   load_reg_y   Reg_Y <= Bus_2
//   load_reg_z   Reg_Z <= ALU zero flag
//   write        memory[Add_R] <= Bus_1
//   alu_sel      ALU operation, NOP when the ALU result is unused
//   halted       high only while halted
module control_unit_risc
   import risc_spm_pkg::*;
#(
   parameter int unsigned word_size  = 8,
   parameter int unsigned op_size    = 4,
   parameter int unsigned state_size = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [word_size-1:0] instruction,
   input  logic                 zero,
   output logic [3:0]           load_r,
   output logic                 load_pc,
   output logic                 inc_pc,
   output logic [2:0]           sel_bus_1,
   output logic [1:0]           sel_bus_2,
   output logic                 load_ir,
   output logic                 load_add_r,
   output logic                 load_reg_y,
   output logic                 load_reg_z,
   output logic                 write,
   output logic [op_size-1:0]   alu_sel,
   output logic                 halted
);

   logic [state_size-1:0] state;
   logic [3:0]            opcode;
   logic [1:0]            src;
   logic [1:0]            dest;

   assign opcode = get_opcode(instruction);
   assign src    = get_src(instruction);
   assign dest   = get_dest(instruction);

   function automatic logic [3:0] dest_onehot(input logic [1:0] d);
      return 4'b0001 << d;
   endfunction

   // Next-state logic and the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= StIdle;
      end else begin
         case (state)
            StIdle: state <= StFet1;
            StFet1: state <= StFet2;
            StFet2: state <= StDec;
            StDec: begin
               case (opcode)
                  OpNop:                      state <= StFet1;
                  OpAdd, OpSub, OpAnd, OpEqz: state <= StEx1;
                  OpNot:                      state <= StFet1;
                  OpRd:                       state <= StRd1;
                  OpWr:                       state <= StWr1;
                  OpBr:                       state <= StBr1;
                  // zero is only looked at here. A BRZ that is not taken skips its operand word.
                  OpBrz:                      state <= zero ? StBr1 : StFet1;
                  default:                    state <= StHalt;
               endcase
            end
            StEx1:  state <= StFet1;
            StRd1:  state <= StRd2;
            StRd2:  state <= StFet1;
            StWr1:  state <= StWr2;
            StWr2:  state <= StFet1;
            StBr1:  state <= StBr2;
            StBr2:  state <= StFet1;
            StHalt: state <= StHalt;
            default: state <= StHalt;
         endcase
      end
   end

   // Output decode
   always_comb begin
      load_r     = 4'b0000;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      sel_bus_1  = Sel1Pc;
      sel_bus_2  = Sel2Bus1;
      load_ir    = 1'b0;
      load_add_r = 1'b0;
      load_reg_y = 1'b0;
      load_reg_z = 1'b0;
      write      = 1'b0;
      alu_sel    = OpNop;
      halted     = 1'b0;

      case (state)
         StFet1: load_add_r = 1'b1;
         StFet2: begin
            sel_bus_2 = Sel2Mem;
            load_ir   = 1'b1;
            inc_pc    = 1'b1;
         end
         StDec: begin
            case (opcode)
               OpAdd, OpSub, OpAnd, OpEqz: begin
                  // Reg_Y holds src, so the ALU computes dest op src in StEx1
                  sel_bus_1  = {1'b0, src};
                  load_reg_y = 1'b1;
               end
               OpNot: begin
                  sel_bus_1  = {1'b0, src};
                  alu_sel    = OpNot;
                  sel_bus_2  = Sel2Alu;
                  load_r     = dest_onehot(dest);
                  load_reg_z = 1'b1;
               end
               OpRd, OpWr, OpBr: load_add_r = 1'b1;
               OpBrz: begin
                  if (zero) load_add_r = 1'b1;
                  else      inc_pc     = 1'b1;
               end
               default: ;
            endcase
         end
         StEx1: begin
            sel_bus_1  = {1'b0, dest};
            alu_sel    = opcode;
            sel_bus_2  = Sel2Alu;
            load_reg_z = 1'b1;
            // EQZ only updates the flag
            if (opcode != OpEqz) load_r = dest_onehot(dest);
         end
         StRd1, StWr1: begin
            sel_bus_2  = Sel2Mem;
            load_add_r = 1'b1;
            inc_pc     = 1'b1;
         end
         StRd2: begin
            sel_bus_2 = Sel2Mem;
            load_r    = dest_onehot(dest);
         end
         StWr2: begin
            sel_bus_1 = {1'b0, src};
            write     = 1'b1;
         end
         StBr1: begin
            sel_bus_2  = Sel2Mem;
            load_add_r = 1'b1;
         end
         StBr2: begin
            sel_bus_2 = Sel2Mem;
            load_pc   = 1'b1;
         end
         StHalt: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit_risc.sv
// Testbench for control_unit_risc. For each instruction the reference model builds the
// cycle-by-cycle list of control words from the instruction's meaning. The bench then checks
// every cycle of the DUT against that list.
module tb_control_unit_risc;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instruction;
   logic       zero;
   logic [3:0] load_r;
   logic       load_pc;
   logic       inc_pc;
   logic [2:0] sel_bus_1;
   logic [1:0] sel_bus_2;
   logic       load_ir;
   logic       load_add_r;
   logic       load_reg_y;
   logic       load_reg_z;
   logic       write;
   logic [3:0] alu_sel;
   logic       halted;

   control_unit_risc #(
      .word_size (8),
      .op_size   (4),
      .state_size(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .instruction(instruction),
      .zero       (zero),
      .load_r     (load_r),
      .load_pc    (load_pc),
      .inc_pc     (inc_pc),
      .sel_bus_1  (sel_bus_1),
      .sel_bus_2  (sel_bus_2),
      .load_ir    (load_ir),
      .load_add_r (load_add_r),
      .load_reg_y (load_reg_y),
      .load_reg_z (load_reg_z),
      .write      (write),
      .alu_sel    (alu_sel),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] load_r;
      logic       load_pc;
      logic       inc_pc;
      logic [2:0] sel_bus_1;
      logic [1:0] sel_bus_2;
      logic       load_ir;
      logic       load_add_r;
      logic       load_reg_y;
      logic       load_reg_z;
      logic       write;
      logic [3:0] alu_sel;
      logic       halted;
   } ctrl_t;

   ctrl_t obs;
   assign obs = {load_r, load_pc, inc_pc, sel_bus_1, sel_bus_2, load_ir, load_add_r,
                 load_reg_y, load_reg_z, write, alu_sel, halted};

   int    checks = 0;
   int    passed = 0;
   ctrl_t exp_q[$];

   // Idle control word: nothing loads, Bus_1 = PC, Bus_2 = Bus_1, ALU NOP
   function automatic ctrl_t idle_word();
      ctrl_t c;
      c           = '0;
      c.sel_bus_1 = 3'd4;
      c.sel_bus_2 = 2'd1;
      return c;
   endfunction

   // Builds the expected control words for one instruction, starting at its first fetch cycle.
   // Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 NOT, 5 RD, 6 WR, 7 BR, 8 BRZ, 9 EQZ, 10+ halt.
   function automatic void build_seq(input logic [7:0] ir, input logic z);
      ctrl_t      c;
      logic [3:0] op;
      logic [1:0] s;
      logic [1:0] d;
      op = ir[7:4];
      s  = ir[3:2];
      d  = ir[1:0];
      exp_q.delete();
      // fetch: Add_R <= PC, then IR <= mem and PC++
      c = idle_word(); c.load_add_r = 1'b1; exp_q.push_back(c);
      c = idle_word(); c.sel_bus_2 = 2'd2; c.load_ir = 1'b1; c.inc_pc = 1'b1; exp_q.push_back(c);
      if (op == 4'd0) begin
         exp_q.push_back(idle_word());
      end else if (op inside {4'd1, 4'd2, 4'd3, 4'd9}) begin
         c = idle_word(); c.sel_bus_1 = {1'b0, s}; c.load_reg_y = 1'b1; exp_q.push_back(c);
         c = idle_word(); c.sel_bus_1 = {1'b0, d}; c.alu_sel = op; c.sel_bus_2 = 2'd0;
         c.load_reg_z = 1'b1;
         if (op != 4'd9) c.load_r = 4'(1 << d);
         exp_q.push_back(c);
      end else if (op == 4'd4) begin
         c = idle_word(); c.sel_bus_1 = {1'b0, s}; c.alu_sel = 4'd4; c.sel_bus_2 = 2'd0;
         c.load_r = 4'(1 << d); c.load_reg_z = 1'b1; exp_q.push_back(c);
      end else if (op == 4'd8 && !z) begin
         c = idle_word(); c.inc_pc = 1'b1; exp_q.push_back(c);
      end else if (op inside {4'd5, 4'd6, 4'd7, 4'd8}) begin
         c = idle_word(); c.load_add_r = 1'b1; exp_q.push_back(c);
         c = idle_word(); c.sel_bus_2 = 2'd2; c.load_add_r = 1'b1;
         c.inc_pc = (op == 4'd5 || op == 4'd6);
         exp_q.push_back(c);
         c = idle_word();
         if (op == 4'd5) begin
            c.sel_bus_2 = 2'd2; c.load_r = 4'(1 << d);
         end else if (op == 4'd6) begin
            c.sel_bus_1 = {1'b0, s}; c.write = 1'b1;
         end else begin
            c.sel_bus_2 = 2'd2; c.load_pc = 1'b1;
         end
         exp_q.push_back(c);
      end else begin
         // decode cycle does nothing, then the halt state is held
         exp_q.push_back(idle_word());
         c = idle_word(); c.halted = 1'b1;
         repeat (3) exp_q.push_back(c);
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1; instruction = 8'h00; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== idle_word())
         $display("FAIL reset_idle: got %h want %h", obs, idle_word());
      else passed++;
      checks++;
      if (load_r !== 4'b0000 || write !== 1'b0)
         $display("FAIL reset_no_load: got load_r=%b write=%b want 0000/0", load_r, write);
      else passed++;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (sel_bus_1 !== 3'd4 || load_add_r !== 1'b1 || load_r !== 4'b0000 || write !== 1'b0)
         $display("FAIL reset_fet1: got sel1=%0d add_r=%b load_r=%b write=%b want 4/1/0000/0",
                  sel_bus_1, load_add_r, load_r, write);
      else passed++;
      // abort from the second fetch cycle, then settle at the first fetch cycle
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== idle_word())
         $display("FAIL reset_from_fet2: got %h want %h", obs, idle_word());
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [8:0] table_v [10];
      table_v = '{{8'h16, 1'b0}, {8'h96, 1'b1}, {8'h80, 1'b0}, {8'h80, 1'b1}, {8'h6C, 1'b0},
                  {8'h4B, 1'b1}, {8'h57, 1'b0}, {8'h73, 1'b0}, {8'h00, 1'b1}, {8'h2D, 1'b0}};
      for (int t = 0; t < 10; t++) begin
         build_seq(table_v[t][8:1], table_v[t][0]);
         for (int i = 0; i < exp_q.size(); i++) begin
            instruction = table_v[t][8:1];
            zero        = (i == 2) ? table_v[t][0] : ~table_v[t][0];
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i])
               $display("FAIL directed ir=%h z=%b cyc %0d: got %h want %h",
                        table_v[t][8:1], table_v[t][0], i, obs, exp_q[i]);
            else passed++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset_mid();
      build_seq(8'h16, 1'b0);
      for (int i = 0; i < 4; i++) begin
         instruction = 8'h16; zero = 1'b0;
         if (i == 3) rst = 1'b1;
         @(negedge clk);
         checks++;
         if (obs !== exp_q[i])
            $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, obs, exp_q[i]);
         else passed++;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== idle_word())
         $display("FAIL reset_mid_idle: got %h want %h", obs, idle_word());
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_halt();
      ctrl_t h;
      h = idle_word(); h.halted = 1'b1;
      build_seq(8'hF0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         instruction = 8'hF0; zero = 1'(i);
         @(negedge clk);
         checks++;
         if (obs !== exp_q[i])
            $display("FAIL halt cyc %0d: got %h want %h", i, obs, exp_q[i]);
         else passed++;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== h) $display("FAIL halt_hold: got %h want %h", obs, h);
      else passed++;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== idle_word())
         $display("FAIL halt_reset_idle: got %h want %h", obs, idle_word());
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [7:0] ir;
      logic       z;
      for (int n = 0; n < 200; n++) begin
         ir = 8'($urandom);
         if (ir[7:4] >= 4'd10 && $urandom_range(0, 3) != 0) ir[7:4] = 4'($urandom_range(0, 9));
         z = 1'($urandom);
         build_seq(ir, z);
         for (int i = 0; i < exp_q.size(); i++) begin
            instruction = ir;
            zero        = (i == 2) ? z : 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i])
               $display("FAIL random ir=%h z=%b cyc %0d: got %h want %h", ir, z, i, obs, exp_q[i]);
            else passed++;
            checks++;
            if ($countones(load_r) > 1 || (write && load_r != 4'b0000))
               $display("FAIL random_exclusive ir=%h cyc %0d: got load_r=%b write=%b", ir, i,
                        load_r, write);
            else passed++;
            @(posedge clk); #1;
         end
         if (ir[7:4] >= 4'd10) begin
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            checks++;
            if (obs !== idle_word())
               $display("FAIL random_reset_idle: got %h want %h", obs, idle_word());
            else passed++;
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid();
      test_halt();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
